// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: ALU function codes, sequencer commands and flag bit positions shared with the ALU
package alu_sequencer_pkg;
    typedef enum logic [1:0] {FnADD = 2'd0, FnLSL = 2'd1, FnLSR = 2'd2, FnMem = 2'd3} alu_functions_t;
    typedef enum logic [1:0] {MUL = 2'd0, SHL = 2'd1, SHR = 2'd2, PASS = 2'd3} seq_cmd_t;
    localparam int Z = 0;
    localparam int C = 1;
    localparam int V = 2;
    localparam int N = 3;
    function automatic logic [3:0] result_flags(input logic [15:0] r, input logic cy);
        return {r[15], 1'b0, cy, r == 16'd0};
    endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command handshake from the control unit plus the bus to the shared ALU
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;
    logic           start;
    seq_cmd_t       cmd;
    logic [15:0]    opa;
    logic [15:0]    opb;
    logic           busy;
    logic           done;
    logic [15:0]    seq_result;
    logic [3:0]     seq_flags;
    alu_functions_t alu_op;
    logic [15:0]    alu_op1;
    logic [15:0]    alu_op2;
    logic [15:0]    alu_result;
    logic [3:0]     alu_flags;
    modport master (output start, cmd, opa, opb, input busy, done, seq_result, seq_flags);
    modport slave (input start, cmd, opa, opb, alu_result, alu_flags,
                   output busy, done, seq_result, seq_flags, alu_op, alu_op1, alu_op2);
    modport alu (input alu_op, alu_op1, alu_op2, output alu_result, alu_flags);
endinterface

// File: rtl/alu_sequencer_exec.sv
// alu_sequencer_exec: the single-cycle ALU and the alu_exec_unit wrapper pairing it with the sequencer
module alu
    import alu_sequencer_pkg::*;
(
    alu_sequencer_if.alu bus
);
    logic [16:0] sum;
    logic        cy;
    assign sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
    always_comb begin
        bus.alu_result = bus.alu_op == FnADD ? sum[15:0]
                       : bus.alu_op == FnLSL ? {bus.alu_op1[14:0], 1'b0}
                       : bus.alu_op == FnLSR ? {1'b0, bus.alu_op1[15:1]} : bus.alu_op1;
        cy = bus.alu_op == FnADD ? sum[16]
           : bus.alu_op == FnLSL ? bus.alu_op1[15]
           : bus.alu_op == FnLSR ? bus.alu_op1[0] : 1'b0;
        bus.alu_flags = {bus.alu_result[15],
                         bus.alu_op == FnADD && bus.alu_op1[15] == bus.alu_op2[15] && sum[15] != bus.alu_op1[15],
                         cy, bus.alu_result == 16'd0};
    end
endmodule

module alu_exec_unit (
    input logic      clock,
    input logic      nreset,
    alu_sequencer_if bus
);
    alu u_alu (.bus(bus));
    alu_sequencer u_seq (.clock(clock), .nreset(nreset), .bus(bus));
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle MUL/SHL/SHR/PASS built from single passes through the shared ALU
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input logic          clock,
    input logic          nreset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MUL_ADD, MUL_SHM, MUL_SHQ, SHIFT, DONE} state_t;
    state_t      state, state_n;
    logic [15:0] acc, m, q, acc_n, m_n, q_n;
    logic [3:0]  cnt, cnt_n;
    logic        cstk, cstk_n, shr;
    logic        is_mul;
    assign is_mul = bus.cmd == MUL;
    assign bus.alu_op = state == MUL_ADD ? FnADD
                      : state == MUL_SHM || (state == SHIFT && !shr) ? FnLSL
                      : state == MUL_SHQ || state == SHIFT ? FnLSR : FnMem;
    assign bus.alu_op1 = state == MUL_SHM ? m : state == MUL_SHQ ? q : acc;
    assign bus.alu_op2 = state == MUL_ADD ? m : 16'd0;
    always_comb begin
        state_n = state;
        acc_n   = acc;
        m_n     = m;
        q_n     = q;
        cnt_n   = cnt;
        cstk_n  = cstk;
        case (state)
            IDLE: if (bus.start) begin
                acc_n   = is_mul ? 16'd0 : bus.opa;
                m_n     = is_mul ? bus.opa : m;
                q_n     = is_mul ? bus.opb : q;
                cnt_n   = bus.cmd == SHL || bus.cmd == SHR ? bus.opb[3:0] : cnt;
                cstk_n  = 1'b0;
                state_n = bus.cmd == PASS ? DONE
                        : is_mul ? (bus.opb == 16'd0 ? DONE : bus.opb[0] ? MUL_ADD : MUL_SHM)
                        : bus.opb[3:0] == 4'd0 ? DONE : SHIFT;
            end
            MUL_ADD: begin
                acc_n   = bus.alu_result;
                cstk_n  = cstk | bus.alu_flags[C];
                state_n = MUL_SHM;
            end
            // Dropping M's top bit only overflows if higher multiplier bits remain
            MUL_SHM: begin
                m_n     = bus.alu_result;
                cstk_n  = cstk | (m[15] & (q[15:1] != 15'd0));
                state_n = MUL_SHQ;
            end
            MUL_SHQ: begin
                q_n     = bus.alu_result;
                state_n = bus.alu_result == 16'd0 ? DONE : bus.alu_result[0] ? MUL_ADD : MUL_SHM;
            end
            SHIFT: begin
                acc_n   = bus.alu_result;
                cstk_n  = shr ? acc[0] : acc[15];
                cnt_n   = cnt - 4'd1;
                state_n = cnt == 4'd1 ? DONE : SHIFT;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state          <= IDLE;
            acc            <= 16'd0;
            m              <= 16'd0;
            q              <= 16'd0;
            cnt            <= 4'd0;
            cstk           <= 1'b0;
            shr            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.seq_result <= 16'd0;
            bus.seq_flags  <= 4'd0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            m        <= m_n;
            q        <= q_n;
            cnt      <= cnt_n;
            cstk     <= cstk_n;
            shr      <= state == IDLE && bus.start ? bus.cmd == SHR : shr;
            bus.busy <= state_n != IDLE;
            bus.done <= state_n == DONE;
            // Results are published on entry to DONE so they are visible with the Done pulse
            if (state_n == DONE) begin
                bus.seq_result <= acc_n;
                bus.seq_flags  <= result_flags(acc_n, cstk_n);
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against an arithmetic reference model
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;
    logic clk = 1'b0;
    logic nreset;
    int checks = 0;
    int failures = 0;
    alu_functions_t trace[$];
    logic [16:0] alu_sum;
    alu_sequencer_if bus();
    alu_sequencer dut (.clock(clk), .nreset(nreset), .bus(bus));
    always #5 clk = ~clk;
    assign alu_sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
    assign bus.alu_result = bus.alu_op == FnADD ? alu_sum[15:0]
                          : bus.alu_op == FnLSL ? bus.alu_op1 << 1
                          : bus.alu_op == FnLSR ? bus.alu_op1 >> 1 : bus.alu_op1;
    assign bus.alu_flags = {bus.alu_result[15], 1'b0,
                            bus.alu_op == FnADD ? alu_sum[16] : bus.alu_op == FnLSL ? bus.alu_op1[15]
                            : bus.alu_op == FnLSR ? bus.alu_op1[0] : 1'b0,
                            bus.alu_result == 16'd0};

    function automatic void model(input int c, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f, output int lat);
        logic [31:0] p;
        int n;
        logic cy;
        n = int'(b[3:0]);
        cy = 1'b0;
        lat = 1;
        if (c == 0) begin
            p = {16'd0, a} * {16'd0, b};
            r = p[15:0];
            cy = p[31:16] != 16'd0;
            for (int i = 0; i < 16; i++) if ((b >> i) != 16'd0) lat += 2 + int'(b[i]);
        end else if (c == 1) begin
            r = a << n;
            cy = n != 0 ? a[16 - n] : 1'b0;
            lat = n + 1;
        end else if (c == 2) begin
            r = a >> n;
            cy = n != 0 ? a[n - 1] : 1'b0;
            lat = n + 1;
        end else r = a;
        f = {r[15], 1'b0, cy, r == 16'd0};
    endfunction

    task automatic run_cmd(input int c, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [15:0] r, output logic [3:0] f);
        trace.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd = seq_cmd_t'(c);
        bus.opa = a;
        bus.opb = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.cmd = seq_cmd_t'($urandom_range(0, 3));
        bus.opa = 16'($urandom);
        bus.opb = 16'($urandom);
        lat = 1;
        while (!bus.done && lat < 200) begin
            trace.push_back(bus.alu_op);
            @(negedge clk);
            lat++;
        end
        r = bus.seq_result;
        f = bus.seq_flags;
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        bus.start = 1'b0;
        bus.cmd = MUL;
        bus.opa = 16'd0;
        bus.opb = 16'd0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        if (bus.seq_result !== 16'd0) begin failures++; $display("FAIL reset_result got=%h want=0000", bus.seq_result); end
        if (bus.alu_op !== FnMem) begin failures++; $display("FAIL reset_aluop got=%0d want=%0d", bus.alu_op, FnMem); end
    endtask

    task automatic test_mul_basic;
        int lat;
        logic [15:0] r;
        logic [3:0] f;
        alu_functions_t exp_tr[$] = '{FnADD, FnLSL, FnLSR, FnLSL, FnLSR, FnADD, FnLSL, FnLSR};
        run_cmd(MUL, 16'd3, 16'd5, lat, r, f);
        checks += 4;
        if (r !== 16'h000F) begin failures++; $display("FAIL mul3x5_result got=%h want=000f", r); end
        if (f !== 4'b0000) begin failures++; $display("FAIL mul3x5_flags got=%b want=0000", f); end
        if (lat != 9) begin failures++; $display("FAIL mul3x5_latency got=%0d want=9", lat); end
        if (trace != exp_tr) begin failures++; $display("FAIL mul3x5_trace got_len=%0d want_len=8", trace.size()); end
    endtask

    task automatic test_overflow;
        int lat;
        logic [15:0] r;
        logic [3:0] f;
        run_cmd(MUL, 16'h0100, 16'h0100, lat, r, f);
        checks += 2;
        if (r !== 16'h0000) begin failures++; $display("FAIL ovf256_result got=%h want=0000", r); end
        if (f !== 4'b0011) begin failures++; $display("FAIL ovf256_flags got=%b want=0011", f); end
        run_cmd(MUL, 16'hFFFF, 16'd2, lat, r, f);
        checks += 2;
        if (r !== 16'hFFFE) begin failures++; $display("FAIL ovfffff_result got=%h want=fffe", r); end
        if (f !== 4'b1010) begin failures++; $display("FAIL ovfffff_flags got=%b want=1010", f); end
    endtask

    task automatic test_shift;
        int lat;
        logic [15:0] r;
        logic [3:0] f;
        run_cmd(SHL, 16'h8001, 16'hFFF1, lat, r, f);
        checks += 3;
        if (r !== 16'h0002) begin failures++; $display("FAIL shl1_result got=%h want=0002", r); end
        if (f !== 4'b0010) begin failures++; $display("FAIL shl1_flags got=%b want=0010", f); end
        if (lat != 2) begin failures++; $display("FAIL shl1_latency got=%0d want=2", lat); end
        run_cmd(SHR, 16'h8001, 16'h000F, lat, r, f);
        checks += 3;
        if (r !== 16'h0001) begin failures++; $display("FAIL shr15_result got=%h want=0001", r); end
        if (f !== 4'b0000) begin failures++; $display("FAIL shr15_flags got=%b want=0000", f); end
        if (lat != 16) begin failures++; $display("FAIL shr15_latency got=%0d want=16", lat); end
    endtask

    task automatic test_zero_cost;
        int lat;
        logic [15:0] r;
        logic [3:0] f;
        run_cmd(MUL, 16'h1234, 16'd0, lat, r, f);
        checks += 3;
        if (r !== 16'h0000) begin failures++; $display("FAIL mul0_result got=%h want=0000", r); end
        if (f !== 4'b0001) begin failures++; $display("FAIL mul0_flags got=%b want=0001", f); end
        if (lat != 1) begin failures++; $display("FAIL mul0_latency got=%0d want=1", lat); end
        run_cmd(SHL, 16'h1234, 16'hABC0, lat, r, f);
        checks += 2;
        if (r !== 16'h1234) begin failures++; $display("FAIL shl0_result got=%h want=1234", r); end
        if (lat != 1) begin failures++; $display("FAIL shl0_latency got=%0d want=1", lat); end
        run_cmd(PASS, 16'h8000, 16'h5555, lat, r, f);
        checks += 3;
        if (r !== 16'h8000) begin failures++; $display("FAIL pass_result got=%h want=8000", r); end
        if (f !== 4'b1000) begin failures++; $display("FAIL pass_flags got=%b want=1000", f); end
        if (lat != 1) begin failures++; $display("FAIL pass_latency got=%0d want=1", lat); end
    endtask

    task automatic test_random;
        int lat, elat, c;
        logic [15:0] r, er, a, b;
        logic [3:0] f, ef;
        for (int i = 0; i < 60; i++) begin
            c = $urandom_range(0, 3);
            a = 16'($urandom);
            b = 16'($urandom) >> $urandom_range(0, 15);
            model(c, a, b, er, ef, elat);
            run_cmd(c, a, b, lat, r, f);
            checks += 3;
            if (r !== er) begin failures++; $display("FAIL rand%0d_result cmd=%0d a=%h b=%h got=%h want=%h", i, c, a, b, r, er); end
            if (f !== ef) begin failures++; $display("FAIL rand%0d_flags cmd=%0d a=%h b=%h got=%b want=%b", i, c, a, b, f, ef); end
            if (lat != elat) begin failures++; $display("FAIL rand%0d_latency cmd=%0d a=%h b=%h got=%0d want=%0d", i, c, a, b, lat, elat); end
        end
    endtask

    task automatic test_start_held;
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd = MUL;
        bus.opa = 16'd3;
        bus.opb = 16'd5;
        @(negedge clk);
        bus.cmd = PASS;
        bus.opa = 16'h00AA;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks += 2;
        if (lat != 9) begin failures++; $display("FAIL held_latency got=%0d want=9", lat); end
        if (bus.seq_result !== 16'h000F) begin failures++; $display("FAIL held_result got=%h want=000f", bus.seq_result); end
        @(negedge clk);
        checks += 2;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL held_idle_busy got=%b want=0", bus.busy); end
        if (bus.seq_result !== 16'h000F) begin failures++; $display("FAIL held_hold_result got=%h want=000f", bus.seq_result); end
        @(negedge clk);
        bus.start = 1'b0;
        checks += 2;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL held_next_done got=%b want=1", bus.done); end
        if (bus.seq_result !== 16'h00AA) begin failures++; $display("FAIL held_next_result got=%h want=00aa", bus.seq_result); end
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        logic [15:0] r;
        logic [3:0] f;
        logic seen;
        run_cmd(PASS, 16'h9234, 16'd0, lat, r, f);
        checks += 1;
        if (r !== 16'h9234) begin failures++; $display("FAIL rst_pre_result got=%h want=9234", r); end
        @(negedge clk);
        bus.start = 1'b1;
        bus.cmd = MUL;
        bus.opa = 16'd3;
        bus.opb = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks += 1;
        if (bus.alu_op !== FnLSL) begin failures++; $display("FAIL rst_in_shm got=%0d want=%0d", bus.alu_op, FnLSL); end
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        checks += 4;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b want=0", bus.done); end
        if (bus.seq_result !== 16'd0) begin failures++; $display("FAIL rst_mid_result got=%h want=0000", bus.seq_result); end
        if (bus.seq_flags !== 4'd0) begin failures++; $display("FAIL rst_mid_flags got=%b want=0000", bus.seq_flags); end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | bus.done | bus.busy;
        end
        checks += 1;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b want=0", seen); end
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_overflow;
        test_shift;
        test_zero_cost;
        test_random;
        test_start_held;
        test_reset_mid_mul;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
